// File: rtl/serial_addsub_digit_if.sv
// rtl/serial_addsub_digit_if.sv - digit-serial add/sub stream bundle
// Purpose: groups the input-digit and result-digit handshakes of serial_addsub_digit.
// Signals:
//   in_valid/in_ready/a/b/sub        : operand digit stream (master drives, slave accepts)
//   out_valid/out_ready/sum/out_last : result digit stream (slave drives, master accepts)
//   carry_out/overflow               : word status, meaningful only with out_last
interface serial_addsub_digit_if #(
    parameter int DIGIT_W = 1
);
    logic               in_valid;
    logic               in_ready;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [DIGIT_W-1:0] sum;
    logic               out_last;
    logic               carry_out;
    logic               overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, out_last, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, out_last, carry_out, overflow
    );
endinterface

// File: rtl/serial_addsub_digit.sv
// rtl/serial_addsub_digit.sv - digit-serial adder/subtractor, LSB digit first
// Purpose: adds or subtracts two NUM_DIGITS*DIGIT_W-bit words one DIGIT_W-bit
//   digit per accepted beat, with one registered output stage.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   flush    : (only with SERIAL_ADDSUB_FLUSH_EN) discard the partial word
//   bus      : serial_addsub_digit_if.slave (operand and result streams)
// Optional feature macro: SERIAL_ADDSUB_FLUSH_EN
module serial_addsub_digit #(
    parameter int DIGIT_W    = 1,
    parameter int NUM_DIGITS = 8
) (
    input logic clk,
    input logic rst,
`ifdef SERIAL_ADDSUB_FLUSH_EN
    input logic flush,
`endif
    serial_addsub_digit_if.slave bus
);
    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]   count;
    logic               carry;
    logic               mode;
    logic               out_valid_q;
    logic [DIGIT_W-1:0] sum_q;
    logic               out_last_q;
    logic               carry_out_q;
    logic               overflow_q;

    logic               flush_i;
    logic               accept;
    logic               first_beat;
    logic               last_beat;
    logic               mode_eff;
    logic               cin;
    logic [DIGIT_W-1:0] s;
    logic               c_top;
    logic               c_msb_in;

`ifdef SERIAL_ADDSUB_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // A flush cycle refuses input so no beat can slip into the discarded word.
    assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~flush_i;
    assign accept       = bus.in_valid & bus.in_ready;
    assign first_beat   = (count == '0);
    assign last_beat    = (count == LAST_CNT);

    // Subtraction is A + ~B + 1: the +1 enters as carry-in of the first digit.
    assign mode_eff = first_beat ? bus.sub : mode;
    assign cin      = first_beat ? bus.sub : carry;

    always_comb begin
        logic cr;
        logic bx;
        s        = '0;
        cr       = cin;
        c_msb_in = cin;
        bx       = 1'b0;
        for (int i = 0; i < DIGIT_W; i++) begin
            bx       = bus.b[i] ^ mode_eff;
            s[i]     = bus.a[i] ^ bx ^ cr;
            c_msb_in = cr;
            cr       = (bus.a[i] & bx) | ((bus.a[i] ^ bx) & cr);
        end
        c_top = cr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            carry       <= 1'b0;
            mode        <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            out_last_q  <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (flush_i) begin
                count <= '0;
                carry <= 1'b0;
            end else if (accept) begin
                count <= last_beat ? '0 : count + 1'b1;
                carry <= last_beat ? 1'b0 : c_top;
                if (first_beat) begin
                    mode <= bus.sub;
                end
            end

            if (accept) begin
                out_valid_q <= 1'b1;
                sum_q       <= s;
                out_last_q  <= last_beat;
                carry_out_q <= last_beat & c_top;
                overflow_q  <= last_beat & (c_top ^ c_msb_in);
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_addsub_digit.sv
// tb/tb_serial_addsub_digit.sv - scoreboard bench for serial_addsub_digit
module tb_serial_addsub_digit;
    typedef struct packed {
        logic [3:0] sum;
        logic       last;
        logic       co;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    exp_t q1[$];
    exp_t q4[$];

    serial_addsub_digit_if #(.DIGIT_W(1)) b1 ();
    serial_addsub_digit_if #(.DIGIT_W(4)) b4 ();

`ifdef SERIAL_ADDSUB_FLUSH_EN
    logic flush1 = 1'b0;
    logic flush4 = 1'b0;
`endif

    serial_addsub_digit #(.DIGIT_W(1), .NUM_DIGITS(8)) u1 (
        .clk(clk),
        .rst(rst),
`ifdef SERIAL_ADDSUB_FLUSH_EN
        .flush(flush1),
`endif
        .bus(b1)
    );

    serial_addsub_digit #(.DIGIT_W(4), .NUM_DIGITS(2)) u4 (
        .clk(clk),
        .rst(rst),
`ifdef SERIAL_ADDSUB_FLUSH_EN
        .flush(flush4),
`endif
        .bus(b4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare whenever a result digit is taken.
    always @(negedge clk) begin
        exp_t got1, e1;
        if (!rst && b1.out_valid && b1.out_ready) begin
            got1 = {3'b000, b1.sum, b1.out_last, b1.carry_out, b1.overflow};
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL mon1_unexpected got=%0h exp=none", got1);
            end else begin
                e1 = q1.pop_front();
                if (got1 !== e1) begin
                    errors++;
                    $display("FAIL mon1_digit got sum=%0h last=%0b co=%0b ov=%0b exp sum=%0h last=%0b co=%0b ov=%0b",
                             got1.sum, got1.last, got1.co, got1.ov, e1.sum, e1.last, e1.co, e1.ov);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t got4, e4;
        if (!rst && b4.out_valid && b4.out_ready) begin
            got4 = {b4.sum, b4.out_last, b4.carry_out, b4.overflow};
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL mon4_unexpected got=%0h exp=none", got4);
            end else begin
                e4 = q4.pop_front();
                if (got4 !== e4) begin
                    errors++;
                    $display("FAIL mon4_digit got sum=%0h last=%0b co=%0b ov=%0b exp sum=%0h last=%0b co=%0b ov=%0b",
                             got4.sum, got4.last, got4.co, got4.ov, e4.sum, e4.last, e4.co, e4.ov);
                end
            end
        end
    end

    task automatic wait_acc1();
        int n;
        n = 0;
        @(negedge clk);
        while (!b1.in_ready) begin
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept1_timeout got=stalled exp=accept");
                break;
            end
            @(negedge clk);
        end
    endtask

    // Streams nb beats of one 8-bit word into u1; later beats drive the
    // opposite sub so a failure to latch the mode shows up.
    task automatic word1(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         input logic [7:0] es, input logic co, input logic ov, input int nb);
        for (int i = 0; i < nb; i++) begin
            @(posedge clk);
            #1;
            b1.in_valid = 1'b1;
            b1.a        = av[i];
            b1.b        = bv[i];
            b1.sub      = (i == 0) ? sv : ~sv;
            wait_acc1();
            q1.push_back({4'(es[i]), (i == 7), (i == 7) & co, (i == 7) & ov});
        end
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid1", 32'(b1.out_valid), 0);
        chk("rst_sum1", 32'(b1.sum), 0);
        chk("rst_flags1", {29'b0, b1.out_last, b1.carry_out, b1.overflow}, 0);
        chk("rst_in_ready1", 32'(b1.in_ready), 1);
        chk("rst_out_valid4", 32'(b4.out_valid), 0);
        chk("rst_sum4", 32'(b4.sum), 0);
        chk("rst_flags4", {29'b0, b4.out_last, b4.carry_out, b4.overflow}, 0);
    endtask

    initial begin
        logic [5:0] pat;
        logic [7:0] av4, bv4;
        logic [3:0] snap_sum;
        logic       snap_last, stalled;
        int         d;

        b1.in_valid = 0; b1.a = 0; b1.b = 0; b1.sub = 0; b1.out_ready = 1;
        b4.in_valid = 0; b4.a = 0; b4.b = 0; b4.sub = 0; b4.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;

        word1(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 8);
        word1(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8);
        word1(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8);
        word1(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 8);
        word1(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8);

        // Reset in the middle of a word: only 3 beats, then a fresh word.
        word1(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 3);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        word1(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 8);

`ifdef SERIAL_ADDSUB_FLUSH_EN
        word1(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0, 5);
        flush1 = 1'b1;
        b1.in_valid = 1'b1; b1.a = 1'b1; b1.b = 1'b1; b1.sub = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(b1.in_ready), 0);
        @(posedge clk);
        #1;
        flush1 = 1'b0;
        b1.in_valid = 1'b0;
        word1(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8);
`endif

        // Four-bit digits, two per word, with downstream stalls.
        pat = 6'b111001;
        av4 = 8'h5A;
        bv4 = 8'h3C;
        d = 0;
        stalled = 1'b0;
        snap_sum = '0;
        snap_last = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (stalled) begin
                chk("stall_hold_valid", 32'(b4.out_valid), 1);
                chk("stall_hold_sum", 32'(b4.sum), 32'(snap_sum));
                chk("stall_hold_last", 32'(b4.out_last), 32'(snap_last));
            end
            b4.out_ready = pat[k];
            if (d < 2) begin
                b4.in_valid = 1'b1;
                b4.a   = av4[4*d +: 4];
                b4.b   = bv4[4*d +: 4];
                b4.sub = 1'b0;
            end else begin
                b4.in_valid = 1'b0;
            end
            @(negedge clk);
            stalled = b4.out_valid & ~b4.out_ready;
            if (stalled) begin
                chk("stall_in_ready", 32'(b4.in_ready), 0);
                snap_sum  = b4.sum;
                snap_last = b4.out_last;
            end
            if (b4.in_valid && b4.in_ready) begin
                if (d == 0) q4.push_back({4'h6, 1'b0, 1'b0, 1'b0});
                else        q4.push_back({4'h9, 1'b1, 1'b0, 1'b1});
                d++;
            end
        end
        chk("u4_beats_accepted", 32'(d), 2);
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;

        repeat (4) @(posedge clk);
        #1;
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q4_drained", 32'(q4.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
